// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU consuming the 3-bit alucontrol code.
// Single-cycle add/sub/and/or/slt; unsigned multiply over WIDTH cycles using
// a shift-add datapath that writes a 2*WIDTH-bit product into hi/lo.
// All outputs are registered. done/illegal are one-cycle pulses.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               illegal_q;

  // Multiply datapath: multiplicand is kept 2*WIDTH wide so it can be
  // shifted left into the upper half; multiplier is consumed LSB first.
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic [2*WIDTH-1:0] acc_d;

  // Single-cycle result for the current alucontrol and operands.
  always_comb begin
    alu_res_d = {WIDTH{1'b0}};
    case (alucontrol)
      3'b010:  alu_res_d = a + b;
      3'b110:  alu_res_d = a - b;
      3'b000:  alu_res_d = a & b;
      3'b001:  alu_res_d = a | b;
      3'b111: begin
        if ($signed(a) < $signed(b)) begin
          alu_res_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          alu_res_d = {WIDTH{1'b0}};
        end
      end
      default: alu_res_d = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Control FSM plus all registered outputs and multiply state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      result_q  <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= {(2*WIDTH){1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      count_q   <= {CW{1'b0}};
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (alucontrol)
              3'b011: begin
                state_q  <= ST_MULT;
                busy_q   <= 1'b1;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= {(2*WIDTH){1'b0}};
                count_q  <= {CW{1'b0}};
              end
              3'b100, 3'b101: begin
                // Unsupported: report, leave architectural state alone.
                done_q    <= 1'b1;
                illegal_q <= 1'b1;
              end
              default: begin
                result_q <= alu_res_d;
                zero_q   <= (alu_res_d == {WIDTH{1'b0}});
                done_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_MULT: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (count_q == LAST_BIT) begin
            // Last multiplier bit: publish the full product.
            hi_q     <= acc_d[2*WIDTH-1:WIDTH];
            lo_q     <= acc_d[WIDTH-1:0];
            result_q <= acc_d[WIDTH-1:0];
            zero_q   <= (acc_d[WIDTH-1:0] == {WIDTH{1'b0}});
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios followed by random
// operations, checked against a plain-arithmetic reference model.
module tb_alu_exec;

  localparam int W = 32;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [2:0]    alucontrol;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  result;
  logic          zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model architectural state
  logic [W-1:0] exp_result;
  logic         exp_zero;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  alu_exec #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .result     (result),
    .zero       (zero),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, ".result"}, 64'(result), 64'(exp_result));
    check_eq({tag, ".zero"},   64'(zero),   64'(exp_zero));
    check_eq({tag, ".hi"},     64'(hi),     64'(exp_hi));
    check_eq({tag, ".lo"},     64'(lo),     64'(exp_lo));
  endtask

  // Updates the model for one accepted operation; returns 1 if illegal.
  function automatic logic model_apply(input logic [2:0] code, input logic [W-1:0] av,
                                       input logic [W-1:0] bv);
    logic [63:0] prod;
    logic [W-1:0] r;
    logic ill;
    ill = 1'b0;
    r = exp_result;
    case (code)
      3'b010: r = W'(av + bv);
      3'b110: r = W'(av - bv);
      3'b000: r = av & bv;
      3'b001: r = av | bv;
      3'b111: r = (int'(av) < int'(bv)) ? 32'd1 : 32'd0;
      3'b011: begin
        prod = {32'd0, av} * {32'd0, bv};
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        r = prod[31:0];
      end
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      exp_result = r;
      exp_zero   = (r == 32'd0);
    end
    return ill;
  endfunction

  // Issue one op; must be called at a negedge, returns at the negedge where
  // done was observed, so successive calls run back-to-back.
  task automatic do_op(input logic [2:0] code, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic noisy);
    logic ill;
    int n;
    int busy_cycles;
    ill = model_apply(code, av, bv);
    start = 1'b1;
    alucontrol = code;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    alucontrol = 3'($urandom_range(0, 7));
    n = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) begin
        busy_cycles++;
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        a = $urandom;
        b = $urandom;
        alucontrol = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
    end while (!done && n < W + 5);
    start = 1'b0;
    check_eq("op.done", 64'(done), 64'd1);
    check_eq("op.illegal", 64'(illegal), 64'(ill));
    check_eq("op.busy", 64'(busy), 64'd0);
    if (code == 3'b011) begin
      check_eq("mult.latency", 64'(n - 1), 64'(W));
      check_eq("mult.busy_cycles", 64'(busy_cycles), 64'(W));
    end else begin
      check_eq("single.latency", 64'(n), 64'd1);
    end
    check_arch("op");
  endtask

  // Idle cycle: done/illegal must have dropped back to 0.
  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
    check_eq("idle.done", 64'(done), 64'd0);
    check_eq("idle.illegal", 64'(illegal), 64'd0);
    check_eq("idle.busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0] codes [8];
    codes = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100, 3'b101};
    reset_n = 1'b0;
    start = 1'b0;
    alucontrol = 3'b000;
    a = '0;
    b = '0;
    exp_result = '0;
    exp_zero = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (3) @(negedge clk);
    check_arch("reset");
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.done", 64'(done), 64'd0);
    check_eq("reset.illegal", 64'(illegal), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops, then illegal leaves state alone
    do_op(3'b010, 32'd7, 32'd5, 1'b0);
    check_eq("add7+5", 64'(result), 64'd12);
    idle_cycle();
    do_op(3'b100, 32'd3, 32'd9, 1'b0);
    check_eq("illegal.keep12", 64'(result), 64'd12);
    idle_cycle();
    do_op(3'b110, 32'd5, 32'd5, 1'b0);
    check_eq("sub.zero", 64'(zero), 64'd1);

    // SLT and wrap
    do_op(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_eq("slt.neg", 64'(result), 64'd1);
    do_op(3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0);
    check_eq("slt.pos", 64'(result), 64'd0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_eq("add.wrap", 64'(zero), 64'd1);

    // Multiply, with ignored start pulses, then back-to-back add
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_eq("mult.hi", 64'(hi), 64'hFFFF_FFFE);
    check_eq("mult.lo", 64'(lo), 64'h0000_0001);
    do_op(3'b010, 32'd2, 32'd3, 1'b0);
    check_eq("b2b.add", 64'(result), 64'd5);
    idle_cycle();
    do_op(3'b011, 32'h0000_FFFF, 32'h0001_0000, 1'b1);
    check_eq("mult2.lo", 64'(lo), 64'hFFFF_0000);
    do_op(3'b011, 32'd0, 32'h1234_5678, 1'b0);
    do_op(3'b101, 32'd1, 32'd1, 1'b0);
    idle_cycle();

    // Reset mid-multiply
    do_op(3'b011, 32'h0001_0003, 32'h0002_0005, 1'b0);
    start = 1'b1;
    alucontrol = 3'b011;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_result = '0;
    exp_zero = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check_arch("abort");
    check_eq("abort.busy", 64'(busy), 64'd0);
    check_eq("abort.done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(3'b010, 32'd1, 32'd1, 1'b0);
    check_eq("post_reset.add", 64'(result), 64'd2);

    // Random operations, occasionally separated by idle cycles
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      case ($urandom_range(0, 3))
        0:       av = 32'd0;
        1:       av = 32'hFFFF_FFFF;
        default: av = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       bv = 32'd0;
        1:       bv = 32'h8000_0000;
        default: bv = $urandom;
      endcase
      if (av == bv && $urandom_range(0, 1) == 1) bv = av;
      do_op(codes[$urandom_range(0, 7)], av, bv, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
